// File: rtl/riscv_lsu.sv
// riscv_lsu: RV32I memory-access stage; drives a word-wide req/ack data bus,
// stalls upstream while an access is outstanding, and flags bad accesses or timeouts.
`default_nettype none

module riscv_lsu #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VALID_I,
  input  logic        LOAD_I,
  input  logic        STORE_I,
  input  logic [2:0]  F3_I,
  input  logic [31:0] ADDR_I,
  input  logic [31:0] WDATA_I,
  input  logic [31:0] ALU_VAL_I,
  input  logic [4:0]  RD_I,
  output logic        STALL_O,
  output logic        VALID_O,
  output logic [4:0]  RD_O,
  output logic [31:0] RD_VAL_O,
  output logic        ERR_O,
  output logic        MREQ,
  output logic        MWE,
  output logic [29:0] MADDR,
  output logic [3:0]  MBE,
  output logic [31:0] MWDATA,
  input  logic [31:0] MRDATA,
  input  logic        MACK
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             is_load_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [4:0]       rd_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic        is_mem;
  logic        f3_ok;
  logic        misaligned;
  logic        bad;
  logic        go;
  logic [3:0]  be_base;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] shifted;
  logic [31:0] load_val;

  always_comb begin
    is_mem = LOAD_I | STORE_I;
    f3_ok  = 1'b0;
    if (LOAD_I && STORE_I) begin
      f3_ok = 1'b0;
    end else if (LOAD_I) begin
      case (F3_I)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      case (F3_I)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
    misaligned = ((F3_I[1:0] == 2'b01) && ADDR_I[0]) ||
                 ((F3_I[1:0] == 2'b10) && (ADDR_I[1:0] != 2'b00));
    bad = !f3_ok || misaligned;
    go  = VALID_I && is_mem && !bad;
  end

  // Narrow stores replicate their data across all lanes; MBE picks the live lanes.
  always_comb begin
    case (F3_I[1:0])
      2'b00: begin
        be_base   = 4'b0001;
        wdata_rep = {4{WDATA_I[7:0]}};
      end
      2'b01: begin
        be_base   = 4'b0011;
        wdata_rep = {2{WDATA_I[15:0]}};
      end
      default: begin
        be_base   = 4'b1111;
        wdata_rep = WDATA_I;
      end
    endcase
    be = STORE_I ? (be_base << ADDR_I[1:0]) : 4'b1111;
  end

  always_comb begin
    shifted = rdata_q >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Reset also releases the stall at once so upstream is never held during reset.
  assign STALL_O = !RST && (((state == IDLE) && go) || (state == ACCESS));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      is_load_q <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rd_q      <= 5'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      VALID_O   <= 1'b0;
      RD_O      <= 5'd0;
      RD_VAL_O  <= 32'd0;
      ERR_O     <= 1'b0;
      MREQ      <= 1'b0;
      MWE       <= 1'b0;
      MADDR     <= 30'd0;
      MBE       <= 4'd0;
      MWDATA    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!VALID_I) begin
            VALID_O <= 1'b0;
          end else if (!is_mem) begin
            VALID_O  <= 1'b1;
            RD_O     <= RD_I;
            RD_VAL_O <= ALU_VAL_I;
            ERR_O    <= 1'b0;
          end else if (bad) begin
            VALID_O  <= 1'b1;
            RD_O     <= 5'd0;
            RD_VAL_O <= 32'd0;
            ERR_O    <= 1'b1;
          end else begin
            state     <= ACCESS;
            VALID_O   <= 1'b0;
            MREQ      <= 1'b1;
            MWE       <= STORE_I;
            MADDR     <= ADDR_I[31:2];
            MBE       <= be;
            MWDATA    <= STORE_I ? wdata_rep : 32'd0;
            cnt       <= '0;
            is_load_q <= LOAD_I;
            f3_q      <= F3_I;
            off_q     <= ADDR_I[1:0];
            rd_q      <= RD_I;
            err_q     <= 1'b0;
          end
        end
        ACCESS: begin
          VALID_O <= 1'b0;
          if (MACK) begin
            MREQ    <= 1'b0;
            rdata_q <= MRDATA;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            MREQ  <= 1'b0;
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          VALID_O <= 1'b1;
          ERR_O   <= err_q;
          if (is_load_q && !err_q) begin
            RD_O     <= rd_q;
            RD_VAL_O <= load_val;
          end else begin
            RD_O     <= 5'd0;
            RD_VAL_O <= 32'd0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed and randomized checks of riscv_lsu against a byte-level memory model.
`default_nettype none

module tb_riscv_lsu;

  localparam int          TMO  = 4;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VALID_I, LOAD_I, STORE_I;
  logic [2:0]  F3_I;
  logic [31:0] ADDR_I, WDATA_I, ALU_VAL_I;
  logic [4:0]  RD_I;
  logic        STALL_O, VALID_O, ERR_O;
  logic [4:0]  RD_O;
  logic [31:0] RD_VAL_O;
  logic        MREQ, MWE, MACK;
  logic [29:0] MADDR;
  logic [3:0]  MBE;
  logic [31:0] MWDATA, MRDATA;

  logic [31:0] bus_mem [16];
  logic [7:0]  ref_mem [64];

  int tests = 0;
  int fails = 0;

  riscv_lsu #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .VALID_I(VALID_I), .LOAD_I(LOAD_I), .STORE_I(STORE_I),
    .F3_I(F3_I), .ADDR_I(ADDR_I), .WDATA_I(WDATA_I), .ALU_VAL_I(ALU_VAL_I), .RD_I(RD_I),
    .STALL_O(STALL_O), .VALID_O(VALID_O), .RD_O(RD_O), .RD_VAL_O(RD_VAL_O), .ERR_O(ERR_O),
    .MREQ(MREQ), .MWE(MWE), .MADDR(MADDR), .MBE(MBE), .MWDATA(MWDATA),
    .MRDATA(MRDATA), .MACK(MACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, 0 when the op is not a legal memory access.
  function automatic int op_size(input logic ld, input logic st, input logic [2:0] f3);
    if (ld && st) return 0;
    if (ld) begin
      case (f3)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  task automatic set_word(input int idx, input logic [31:0] w);
    bus_mem[idx] = w;
    for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = w[8*b +: 8];
  endtask

  // wait_cyc: ACCESS cycles before MACK; negative means the bus never answers.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] alu, input logic [4:0] rd, input int wait_cyc);
    int          size, off, k, exp_cycles;
    logic        mem, legal, acked;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_val;
    mem   = ld | st;
    size  = op_size(ld, st, f3);
    legal = mem && (size != 0) && ((addr % size) == 0);
    VALID_I = 1'b1; LOAD_I = ld; STORE_I = st; F3_I = f3;
    ADDR_I = addr; WDATA_I = wdata; ALU_VAL_I = alu; RD_I = rd;
    #1;
    check("stall_idle", 32'(STALL_O), 32'(legal));
    if (!legal) begin
      @(posedge CLK); @(negedge CLK);
      check("valid_1cyc", 32'(VALID_O), 32'd1);
      check("err_1cyc", 32'(ERR_O), 32'(mem));
      check("rd_1cyc", 32'(RD_O), mem ? 32'd0 : 32'(rd));
      check("val_1cyc", RD_VAL_O, mem ? 32'd0 : alu);
      check("no_req", 32'(MREQ), 32'd0);
    end else begin
      off    = int'(addr - BASE);
      exp_be = st ? 4'b0000 : 4'b1111;
      exp_wd = 32'd0;
      for (int i = 0; i < size && st; i++) exp_be[(off % 4) + i] = 1'b1;
      for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wdata[8*(j % size) +: 8];
      exp_val = 32'd0;
      for (int i = 0; i < size; i++) exp_val[8*i +: 8] = ref_mem[off + i];
      if (!f3[2] && size < 4 && exp_val[8*size-1])
        for (int i = 8*size; i < 32; i++) exp_val[i] = 1'b1;
      @(posedge CLK); @(negedge CLK);
      check("mreq_on", 32'(MREQ), 32'd1);
      check("mwe", 32'(MWE), 32'(st));
      check("maddr", 32'(MADDR), addr >> 2);
      check("mbe", 32'(MBE), 32'(exp_be));
      if (st) check("mwdata", MWDATA, exp_wd);
      check("valid_busy", 32'(VALID_O), 32'd0);
      k = 0;
      acked = 1'b0;
      while (MREQ === 1'b1 && k < 20) begin
        check("stall_access", 32'(STALL_O), 32'd1);
        if (k == wait_cyc) begin
          MACK   = 1'b1;
          MRDATA = bus_mem[MADDR[3:0]];
          acked  = 1'b1;
          if (MWE)
            for (int b = 0; b < 4; b++)
              if (MBE[b]) bus_mem[MADDR[3:0]][8*b +: 8] = MWDATA[8*b +: 8];
        end
        @(posedge CLK); @(negedge CLK);
        MACK   = 1'b0;
        MRDATA = $urandom;
        k++;
      end
      exp_cycles = (wait_cyc >= 0 && wait_cyc < TMO) ? wait_cyc + 1 : TMO;
      check("mreq_cycles", 32'(k), 32'(exp_cycles));
      if (st && acked)
        for (int i = 0; i < size; i++) ref_mem[off + i] = wdata[8*i +: 8];
      check("stall_done", 32'(STALL_O), 32'd0);
      check("valid_done", 32'(VALID_O), 32'd0);
      MACK   = 1'b1;
      MRDATA = 32'hDEAD_BEEF;
      @(posedge CLK); @(negedge CLK);
      MACK = 1'b0;
      check("valid_mem", 32'(VALID_O), 32'd1);
      check("err_mem", 32'(ERR_O), 32'(!acked));
      check("rd_mem", 32'(RD_O), (ld && acked) ? 32'(rd) : 32'd0);
      check("val_mem", RD_VAL_O, (ld && acked) ? exp_val : 32'd0);
      check("back_idle", 32'(MREQ), 32'd0);
    end
    VALID_I = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("valid_pulse", 32'(VALID_O), 32'd0);
  endtask

  initial begin
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r, w;
    RST = 1'b1; VALID_I = 1'b0; LOAD_I = 1'b0; STORE_I = 1'b0; F3_I = 3'd0;
    ADDR_I = 32'd0; WDATA_I = 32'd0; ALU_VAL_I = 32'd0; RD_I = 5'd0;
    MACK = 1'b0; MRDATA = 32'd0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    set_word(0, 32'h80FF_7F01);
    repeat (2) @(negedge CLK);
    check("rst_valid", 32'(VALID_O), 32'd0);
    check("rst_mreq", 32'(MREQ), 32'd0);
    check("rst_rdval", RD_VAL_O, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    run_op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h1234, 5'd5, 0);
    run_op(1'b1, 1'b0, 3'd0, BASE + 2, 32'd0, 32'd0, 5'd7, 1);
    run_op(1'b1, 1'b0, 3'd4, BASE + 2, 32'd0, 32'd0, 5'd8, 0);
    run_op(1'b1, 1'b0, 3'd1, BASE + 2, 32'd0, 32'd0, 5'd9, 2);
    run_op(1'b0, 1'b1, 3'd1, BASE + 2, 32'hAABB_CCDD, 32'd0, 5'd3, 1);
    run_op(1'b1, 1'b0, 3'd2, BASE, 32'd0, 32'd0, 5'd10, 0);
    run_op(1'b1, 1'b0, 3'd2, BASE + 1, 32'd0, 32'd0, 5'd4, 0);
    run_op(1'b1, 1'b0, 3'd3, BASE + 4, 32'd0, 32'd0, 5'd4, 0);
    run_op(1'b1, 1'b1, 3'd2, BASE + 4, 32'd0, 32'd0, 5'd4, 0);
    run_op(1'b1, 1'b0, 3'd2, BASE + 8, 32'd0, 32'd0, 5'd6, -1);
    run_op(1'b0, 1'b1, 3'd0, BASE + 9, 32'h0000_0055, 32'd0, 5'd0, -1);
    run_op(1'b1, 1'b0, 3'd5, BASE + 6, 32'd0, 32'd0, 5'd0, 0);

    // Reset in the middle of an access.
    VALID_I = 1'b1; LOAD_I = 1'b1; STORE_I = 1'b0; F3_I = 3'd2;
    ADDR_I = BASE + 12; RD_I = 5'd11;
    @(posedge CLK); @(negedge CLK);
    check("pre_rst_mreq", 32'(MREQ), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_mid_mreq", 32'(MREQ), 32'd0);
    check("rst_mid_stall", 32'(STALL_O), 32'd0);
    check("rst_mid_valid", 32'(VALID_O), 32'd0);
    @(negedge CLK);
    VALID_I = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    run_op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'hCAFE_0001, 5'd12, 0);

    for (int n = 0; n < 60; n++) begin
      r  = int'($urandom % 8);
      ld = (r >= 2 && r <= 4) || r == 7;
      st = (r >= 5);
      f3 = ld ? 3'($urandom % 8) : 3'($urandom % 4);
      a  = BASE + ($urandom % 64);
      w  = ($urandom % 8 == 0) ? -1 : int'($urandom % 3);
      run_op(ld, st, f3, a, $urandom, $urandom, 5'($urandom), w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Memory-access (MEM) stage of the RV32I pipeline, between the EX/MEM and MEM/WB registers.
- Executes loads and stores against a variable-latency, word-wide data memory using a req/ack handshake.
- Stalls upstream while an access is outstanding; passes non-memory results through with 1-cycle latency.
- Flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum ACCESS-state cycles without MACK before a bus error (1..65535).
- CNT_W, 16: width of the timeout counter.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- VALID_I  in  1  instruction present from EX/MEM
- LOAD_I  in  1  instruction is a load
- STORE_I  in  1  instruction is a store
- F3_I  in  3  funct3 of the instruction
- ADDR_I  in  32  effective byte address
- WDATA_I  in  32  store data (rs2)
- ALU_VAL_I  in  32  EX result for non-memory instructions
- RD_I  in  5  destination register
- STALL_O  out  1  upstream must hold all inputs stable
- VALID_O  out  1  result valid toward MEM/WB
- RD_O  out  5  destination register toward WB (0 = no write)
- RD_VAL_O  out  32  writeback value
- ERR_O  out  1  misaligned, illegal or timeout; qualified by VALID_O
- MREQ  out  1  memory request
- MWE  out  1  write enable
- MADDR  out  30  word address (byte address bits [31:2])
- MBE  out  4  byte enables; lane 0 = bits [7:0] = byte offset 0 (little-endian)
- MWDATA  out  32  write data
- MRDATA  in  32  read data, valid when MACK=1
- MACK  in  1  access complete

Behaviour:
- Reset: RST is asynchronous and active-high; clock is CLK. Reset forces state IDLE and drives all registered outputs to 0, including MREQ, which drops immediately even mid-access. The in-flight access is abandoned.
- FSM states: IDLE, ACCESS, DONE.
- Legal ops:
  - Loads: F3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: F3 000 SB, 001 SH, 010 SW.
- Illegal: LOAD_I and STORE_I both set, or any other F3 value.
- Misaligned: halfword with ADDR_I[0]=1, or word with ADDR_I[1:0]!=0.
- IDLE, VALID_I=0: VALID_O<=0 at the next edge.
- IDLE, non-memory op (LOAD_I=STORE_I=0): STALL_O=0. Next edge: VALID_O<=1, RD_O<=RD_I, RD_VAL_O<=ALU_VAL_I, ERR_O<=0.
- IDLE, illegal or misaligned memory op: no memory access, STALL_O=0. Next edge: VALID_O<=1, RD_O<=0, RD_VAL_O<=0, ERR_O<=1.
- IDLE, legal memory op:
  - STALL_O=1 combinationally.
  - Next edge: go to ACCESS, MREQ<=1, latch MADDR, MWE, MBE and MWDATA, clear the counter, VALID_O<=0.
- ACCESS:
  - STALL_O=1; MREQ and the memory outputs are held stable; the counter increments each cycle.
  - Edge with MACK=1: MREQ<=0, latch MRDATA, go to DONE.
  - Counter reaching TIMEOUT with MACK=0: MREQ<=0, set the error flag, go to DONE.
  - MACK sampled while MREQ=0 is ignored.
- DONE:
  - STALL_O=0; upstream advances at this edge.
  - Next edge: VALID_O<=1 and ERR_O<=error flag, then return to IDLE.
  - Load without error: RD_O<=RD_I and RD_VAL_O<=extracted value.
  - Store or error: RD_O<=0 and RD_VAL_O<=0.
  - The new instruction presented after DONE is evaluated in IDLE, so there is one bubble after each memory op.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: VALID_O rises at T+3+w, where T is the accept cycle and w is the number of ACCESS cycles before MACK.
- VALID_O is a one-cycle pulse per instruction and is 0 while stalled.
- Loads: MBE=1111, MWE=0. The value is taken from the lane at ADDR[1:0]:
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Stores: MWE=1.
  - SB: MBE=0001<<ADDR[1:0], MWDATA={4{WDATA_I[7:0]}}.
  - SH: MBE=0011<<ADDR[1:0], MWDATA={2{WDATA_I[15:0]}}.
  - SW: MBE=1111, MWDATA=WDATA_I.
- RD_I=0 on a load is performed normally with RD_O=0.

Test Plan:
- Reset, then ADD result ALU_VAL_I=0x1234, RD_I=5, VALID_I=1 -> next cycle VALID_O=1, RD_O=5, RD_VAL_O=0x1234, STALL_O=0 throughout.
- Memory holds word 0x80FF7F01 at 0x00100000; LB addr 0x00100002 with MACK after 2 cycles -> MREQ high 2 cycles with MBE=1111, MADDR=0x00040000; VALID_O with RD_VAL_O=0xFFFFFFFF. LBU at the same address -> 0x000000FF; LH at 0x00100002 -> 0xFFFF80FF.
- SH addr 0x00100002, WDATA_I=0xAABBCCDD -> MWE=1, MBE=1100, MWDATA=0xCCDDCCDD; VALID_O with RD_O=0, ERR_O=0.
- LW addr 0x00100001 -> no MREQ, STALL_O=0, next cycle VALID_O=1, ERR_O=1, RD_O=0; same for F3=011 load.
- TIMEOUT=4, MACK held low -> MREQ high exactly 4 cycles, then VALID_O=1, ERR_O=1, RD_O=0, FSM back in IDLE.
- Assert RST during ACCESS -> MREQ, STALL_O and VALID_O drop immediately; after release a non-memory op completes in 1 cycle.
